// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic MIPS-style instructions into 32-bit words and streams them out through a small FIFO
module instr_encoder #(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [3:0]               op_sel,
   input  logic [4:0]               rs,
   input  logic [4:0]               rt,
   input  logic [4:0]               rd,
   input  logic [15:0]              imm,
   input  logic [25:0]              target,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [31:0]              ins_out,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     illegal_op,
   output logic [15:0]              words_out
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   localparam logic [5:0] OP_ANDR = 6'b100000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_JR   = 6'b001000;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_NORR = 6'b100110;
   localparam logic [5:0] OP_NORI = 6'b001110;
   localparam logic [5:0] OP_NOTR = 6'b000100;
   localparam logic [5:0] OP_BLEU = 6'b010000;
   localparam logic [5:0] OP_ROLV = 6'b000000;
   localparam logic [5:0] OP_RORV = 6'b000010;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [31:0]   word;
   logic          legal, accept, push, pop;

   // format each mnemonic, zeroing every field its format does not use
   always_comb begin
      word  = '0;
      legal = 1'b1;
      case (op_sel)
         4'd0:    word = {OP_ANDR, rs, rt, rd, 11'b0};
         4'd1:    word = {OP_LW, rs, rt, imm};
         4'd2:    word = {OP_SW, rs, rt, imm};
         4'd3:    word = {OP_JR, rs, 21'b0};
         4'd4:    word = {OP_JAL, target};
         4'd5:    word = {OP_NORR, rs, rt, rd, 11'b0};
         4'd6:    word = {OP_NORI, rs, rt, imm};
         4'd7:    word = {OP_NOTR, rs, 5'b0, rd, 11'b0};
         4'd8:    word = {OP_BLEU, rs, rt, imm};
         4'd9:    word = {OP_ROLV, rs, rt, rd, 11'b0};
         4'd10:   word = {OP_RORV, rs, rt, rd, 11'b0};
         default: legal = 1'b0;
      endcase
   end

   assign in_ready  = count != FULL;
   assign out_valid = count != '0;
   assign accept    = in_valid & in_ready;
   assign push      = accept & legal;
   assign pop       = out_valid & out_ready;
   assign ins_out   = out_valid ? mem[rptr] : '0;

   // storage array needs no reset: the head is gated to zero while empty
   always_ff @(posedge clock)
      if (push) mem[wptr] <= word;

   // pointers, occupancy, pop counter and the illegal-op pulse
   always_ff @(posedge clock) begin
      if (reset) begin
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
         words_out  <= '0;
         illegal_op <= 1'b0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         if (pop) words_out <= words_out + 1'b1;
         if (push & ~pop) count <= count + 1'b1;
         else if (pop & ~push) count <= count - 1'b1;
         illegal_op <= accept & ~legal;
      end
   end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder
module tb_instr_encoder;
   logic        clock, reset;
   logic [3:0]  op_sel;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;
   logic [25:0] target;
   logic        in_valid, in_ready, out_valid, out_ready, illegal_op;
   logic [31:0] ins_out;
   logic [2:0]  count;
   logic [15:0] words_out;

   int total = 0;
   int bad = 0;
   logic [31:0] q[$];

   instr_encoder #(.DEPTH(4)) dut (
      .clock(clock), .reset(reset), .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd),
      .imm(imm), .target(target), .in_valid(in_valid), .in_ready(in_ready),
      .ins_out(ins_out), .out_valid(out_valid), .out_ready(out_ready),
      .count(count), .illegal_op(illegal_op), .words_out(words_out)
   );

   initial clock = 0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] a, b, c,
                                       input logic [15:0] i, input logic [25:0] t);
      logic [5:0] opc [11] = '{6'h20, 6'h23, 6'h2B, 6'h08, 6'h03, 6'h26,
                               6'h0E, 6'h04, 6'h10, 6'h00, 6'h02};
      logic [31:0] w;
      w = {opc[op], 26'b0};
      if (op == 1 || op == 2 || op == 6 || op == 8) w[25:0] = {a, b, i};
      else if (op == 3) w[25:21] = a;
      else if (op == 4) w[25:0] = t;
      else if (op == 7) w[25:0] = {a, 5'b0, c, 11'b0};
      else w[25:0] = {a, b, c, 11'b0};
      return w;
   endfunction

   // pops compare the FIFO head against the oldest expected word
   always @(negedge clock) begin
      if (!reset) begin
         if (!out_valid) chk("idle_zero", ins_out, 0);
         else if (out_ready) begin
            if (q.size() == 0) chk("spurious_pop", 1, 0);
            else chk("pop", ins_out, q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [3:0] op, input logic [4:0] a, b, c,
                       input logic [15:0] i, input logic [25:0] t, input logic [31:0] exp);
      op_sel = op; rs = a; rt = b; rd = c; imm = i; target = t;
      in_valid = 1;
      for (int n = 0; n < 20 && !in_ready; n++) tick();
      if (!in_ready) chk("timeout_ready", 0, 1);
      else if (op <= 10) q.push_back(exp);
      tick();
      in_valid = 0;
   endtask

   task automatic send_rand();
      logic [3:0] op;
      logic [4:0] a, b, c;
      logic [15:0] i;
      logic [25:0] t;
      op = 4'($urandom_range(0, 10));
      a = 5'($urandom); b = 5'($urandom); c = 5'($urandom);
      i = 16'($urandom); t = 26'($urandom);
      send(op, a, b, c, i, t, enc(op, a, b, c, i, t));
   endtask

   task automatic drain();
      out_ready = 1;
      for (int n = 0; n < 20 && out_valid; n++) tick();
      chk("drain_empty", out_valid, 0);
   endtask

   task automatic do_reset();
      reset = 1;
      tick();
      reset = 0;
      q.delete();
   endtask

   initial begin
      reset = 1; in_valid = 0; out_ready = 0;
      op_sel = 0; rs = 0; rt = 0; rd = 0; imm = 0; target = 0;
      tick(); tick();
      reset = 0;
      chk("rst_count", count, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_ins_out", ins_out, 0);
      chk("rst_illegal", illegal_op, 0);
      chk("rst_words", words_out, 0);

      send(1, 2, 3, 31, 16'h0010, '1, 32'h8C430010);
      chk("lw_word", ins_out, 32'h8C430010);
      chk("lw_valid", out_valid, 1);
      chk("lw_count", count, 1);
      drain();

      do_reset();
      out_ready = 1;
      send(0, 1, 2, 3, 16'hABCD, '1, 32'h80221800);
      send(3, 31, 7, 9, 16'h1234, '1, 32'h23E00000);
      send(4, 5, 6, 7, 16'hFFFF, 26'h0000100, 32'h0C000100);
      send(8, 4, 5, 31, 16'hFFFE, '1, 32'h4085FFFE);
      drain();
      chk("mix_words", words_out, 4);

      out_ready = 0;
      repeat (4) send_rand();
      chk("full_count", count, 4);
      chk("full_ready", in_ready, 0);
      in_valid = 1; op_sel = 0;
      tick();
      chk("full_no_push", count, 4);
      chk("full_hold", ins_out, q[0]);
      out_ready = 1;
      tick();
      in_valid = 0; out_ready = 0;
      chk("full_pop_count", count, 3);
      chk("full_pop_ready", in_ready, 1);
      drain();

      out_ready = 0;
      send(12, 1, 1, 1, 16'h1, 26'h1, 0);
      chk("ill_pulse", illegal_op, 1);
      chk("ill_count", count, 0);
      chk("ill_valid", out_valid, 0);
      tick();
      chk("ill_one_cycle", illegal_op, 0);
      send(11, 0, 0, 0, 0, 0, 0);
      chk("ill_b2b_a", illegal_op, 1);
      send(15, 0, 0, 0, 0, 0, 0);
      chk("ill_b2b_b", illegal_op, 1);
      tick();
      chk("ill_b2b_end", illegal_op, 0);
      out_ready = 1;
      send(6, 0, 1, 22, 16'h00FF, '1, 32'h380100FF);
      drain();
      out_ready = 0;
      send_rand();
      chk("ill_pop_pre", count, 1);
      out_ready = 1;
      send(13, 0, 0, 0, 0, 0, 0);
      out_ready = 0;
      chk("ill_pop_count", count, 0);
      chk("ill_pop_pulse", illegal_op, 1);
      op_sel = 12; in_valid = 1; reset = 1;
      tick();
      reset = 0; in_valid = 0;
      chk("ill_rst_supp", illegal_op, 0);

      do_reset();
      out_ready = 1;
      for (int k = 0; k < 10; k++) begin
         send_rand();
         chk("stream_count", count, 1);
      end
      tick();
      out_ready = 0;
      repeat (2) send_rand();
      chk("pre_rst_count", count, 2);
      chk("pre_rst_q", q.size(), 2);
      chk("pre_rst_words", words_out, 10);
      do_reset();
      chk("mid_rst_count", count, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_words", words_out, 0);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_ins", ins_out, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming instruction encoder for the project's custom MIPS-style ISA: the inverse of the control decoder. It accepts one symbolic instruction per handshake (mnemonic select plus register/immediate/target fields), packs it into the 32-bit word that the decoder consumes, and buffers results in a small FIFO. The FIFO drains over a valid/ready stream toward the instruction-memory loader. Illegal mnemonic selects are consumed, flagged and dropped.

## Interface

- `DEPTH`, default 4: FIFO depth in words; must be a power of two, ≥2.
- `clock` input 1: single clock; all logic is rising-edge.
- `reset` input 1: synchronous, active-high.
- `op_sel` input 4: mnemonic select. 0 andr, 1 lw, 2 sw, 3 jr, 4 jal, 5 norr, 6 nori, 7 notr, 8 bleu, 9 rolv, 10 rorv. Values 11–15 are illegal.
- `rs`, `rt`, `rd` input 5 each: register fields.
- `imm` input 16: immediate.
- `target` input 26: jump target.
- `in_valid` input 1: fields valid.
- `in_ready` output 1: encoder can accept.
- `ins_out` output 32: encoded word at FIFO head.
- `out_valid` output 1: `ins_out` valid.
- `out_ready` input 1: consumer accepts.
- `count` output $clog2(DEPTH)+1: FIFO occupancy.
- `illegal_op` output 1: one-cycle pulse when an illegal `op_sel` was consumed.
- `words_out` output 16: running count of words popped; wraps at 0xFFFF→0.

## Operation

- Opcodes (`ins[31:26]`):
  - andr 100000, lw 100011, sw 101011, jr 001000, jal 000011, norr 100110
  - nori 001110, notr 000100, bleu 010000, rolv 000000, rorv 000010
- Formats:
  - R (andr, norr, rolv, rorv): {op, rs, rt, rd, 11'b0}.
  - notr: {op, rs, 5'b0, rd, 11'b0}.
  - I (lw, sw, nori, bleu): {op, rs, rt, imm}.
  - jr: {op, rs, 21'b0}.
  - jal: {op, target}.
  - Fields unused by a format are ignored and must not leak into the word.
- Accept: `in_valid & in_ready` in a cycle.
  - Legal op: the encoded word is written at the FIFO tail.
  - Illegal op: nothing is written; `illegal_op`=1 in the next cycle only.
- Pop: `out_valid & out_ready`. The head advances and `words_out` increments by 1 (16-bit, wraps).
- FIFO:
  - Circular buffer with read/write pointers of $clog2(DEPTH) bits, wrapping at DEPTH-1→0.
  - `count` tracks occupancy 0..DEPTH.
  - `in_ready` = (`count` != DEPTH), registered-equivalent: it depends only on state, not on `out_ready`. When full, no push occurs even if a pop happens in the same cycle.
  - `out_valid` = (`count` != 0).
  - `ins_out` holds the head word while `out_valid` and `!out_ready`, and stays stable under backpressure.
- Simultaneous legal push and pop with 0<`count`<DEPTH: both occur and `count` is unchanged.
- An illegal accept with a simultaneous pop: pop only, so `count` decrements.

## Timing

- Reset values:
  - `count`=0, pointers=0, `in_ready`=1, `out_valid`=0.
  - `ins_out`=0 when empty.
  - `illegal_op`=0, `words_out`=0.
- Reset mid-operation discards all buffered words. It also suppresses any `illegal_op` pulse pending from the accept cycle.
- Latency: an accepted legal word appears on `ins_out` with `out_valid`=1 on the cycle after the accept, if the FIFO was empty. There is no combinational input→output bypass.
- Throughput: one accept and one pop per cycle sustained when neither side stalls.
- `ins_out` is 0 whenever `out_valid`=0.
- The `illegal_op` pulse is exactly one cycle wide per illegal accept. Back-to-back illegal accepts give back-to-back pulses.

## Test plan

- **lw encoding.** Reset, then accept lw with rs=2, rt=3, imm=0x0010, rd=31, target=all-ones.
  - Next cycle: `ins_out`=0x8C430010, `out_valid`=1, `count`=1.
- **R-type / jump mix.** Accept in sequence:
  - andr rs=1 rt=2 rd=3 → 0x80221800
  - jr rs=31 → 0x23E00000
  - jal target=0x0000100 → 0x0C000100
  - bleu rs=4 rt=5 imm=0xFFFE → 0x4085FFFE
  - With `out_ready`=1, the words pop in that order and `words_out`=4.
- **Full / backpressure (DEPTH=4).** With `out_ready`=0, push 4 words.
  - `count`=4 and `in_ready`=0; a 5th `in_valid` is not accepted.
  - `ins_out` holds the first word. Raise `out_ready` for one cycle: `count`=3 and `in_ready`=1.
- **Illegal op.** Accept `op_sel`=12.
  - `illegal_op`=1 for exactly one cycle; `count` is unchanged; `out_valid` stays 0.
  - A following legal nori rs=0 rt=1 imm=0x00FF encodes to 0x380100FF.
- **Wrap-around and concurrency.** Stream 10 words with `in_valid` and `out_ready` continuously high.
  - Words emerge in order, one per cycle after the first, and `count` stays at 1.
  - Then assert `reset` with 2 words buffered: next cycle `count`=0, `out_valid`=0, `words_out`=0, `in_ready`=1.
